slot_game_ctrl: RTL

Round sequencer and credit manager for the three-reel slot machine. It sits between the player buttons/coin input and the `slot` reel block. It issues single-cycle start/stop commands to the reels, waits for them to settle, scores the three reel digits and pays winnings into a saturating credit counter. Its outputs drive the reel block, a win lamp and the credit display.

---
 rtl/slot_pkg.sv | 39 +++
 rtl/btn_edge.sv | 22 ++
 rtl/slot_game_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// Shared types for the slot machine round controller: FSM states, win classes,
// reel digit width and the scoring rule.
package slot_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        IDLE,
        SPINNING,
        STOPPING,
        EVAL,
        PAYOUT
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE    = 2'd0,
        WIN_PAIR    = 2'd1,
        WIN_TRIPLE  = 2'd2,
        WIN_JACKPOT = 2'd3
    } win_class_e;

    // Jackpot beats triple beats pair; a pair only counts between adjacent reels.
    function automatic win_class_e score_reels(input digit_t r0,
                                               input digit_t r1,
                                               input digit_t r2,
                                               input digit_t jackpot_sym);
        win_class_e result;
        result = WIN_NONE;
        if (r0 == r1 && r1 == r2) begin
            result = (r0 == jackpot_sym) ? WIN_JACKPOT : WIN_TRIPLE;
        end else if (r0 == r1 || r1 == r2) begin
            result = WIN_PAIR;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already synchronised, debounced button level.
// The edge is visible in the same cycle the level first reads high.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= btn;
        end
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/slot_game_ctrl.sv
// Round sequencer and credit manager: starts/stops the reels, scores the
// settled digits and pays winnings into a saturating credit counter.
module slot_game_ctrl
    import slot_pkg::*;
#(
    parameter int     CREDIT_W    = 8,
    parameter int     MAX_CREDIT  = 99,
    parameter int     PAY2        = 2,
    parameter int     PAY3        = 10,
    parameter int     PAY_JACKPOT = 50,
    parameter digit_t JACKPOT_SYM = 4'h7,
    parameter int     AUTO_STOP   = 256,
    parameter int     PAY_TICK    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                coin,
    input  logic                reels_done,
    input  logic [DIGIT_W-1:0]  reel0,
    input  logic [DIGIT_W-1:0]  reel1,
    input  logic [DIGIT_W-1:0]  reel2,
    output logic                slot_start,
    output logic                slot_stop,
    output logic [CREDIT_W-1:0] credits,
    output logic [1:0]          win_class,
    output logic                win_lamp,
    output logic                busy
);

    localparam int SPIN_W = $clog2(AUTO_STOP + 1);
    localparam int TICK_W = $clog2(PAY_TICK + 1);
    localparam int PAY_W  = $clog2(PAY2 + PAY3 + PAY_JACKPOT + 1);
    localparam int SUM_W  = CREDIT_W + 2;

    localparam logic [SPIN_W-1:0]   SPIN_LAST = SPIN_W'(AUTO_STOP - 1);
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(PAY_TICK - 1);
    localparam logic [SUM_W-1:0]    SUM_MAX   = SUM_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] CRED_MAX  = CREDIT_W'(MAX_CREDIT);

    state_e              state;
    logic [SPIN_W-1:0]   spin_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [PAY_W-1:0]    remaining;
    digit_t              held0;
    digit_t              held1;
    digit_t              held2;

    logic                start_rise;
    logic                stop_rise;
    logic                start_ok;
    logic                pay_now;
    logic [SUM_W-1:0]    credit_sum;
    logic [CREDIT_W-1:0] credit_next;
    win_class_e          score;
    logic [PAY_W-1:0]    payout;

    btn_edge u_start_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (start),
        .rise  (start_rise)
    );

    btn_edge u_stop_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (stop),
        .rise  (stop_rise)
    );

    // Coin, payout tick and start deduction are summed before saturating, so a
    // coin paying for the round at the ceiling nets to zero rather than -1.
    always_comb begin
        start_ok    = (state == IDLE) && start_rise && (credits != '0);
        pay_now     = (state == PAYOUT) && (tick_cnt == TICK_LAST);
        credit_sum  = SUM_W'(credits) + SUM_W'(coin) + SUM_W'(pay_now)
                    - SUM_W'(start_ok);
        credit_next = (credit_sum > SUM_MAX) ? CRED_MAX : credit_sum[CREDIT_W-1:0];
    end

    always_comb begin
        score = score_reels(held0, held1, held2, JACKPOT_SYM);
        case (score)
            WIN_PAIR:    payout = PAY_W'(PAY2);
            WIN_TRIPLE:  payout = PAY_W'(PAY3);
            WIN_JACKPOT: payout = PAY_W'(PAY_JACKPOT);
            default:     payout = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            spin_cnt   <= '0;
            tick_cnt   <= '0;
            remaining  <= '0;
            held0      <= '0;
            held1      <= '0;
            held2      <= '0;
            credits    <= '0;
            slot_start <= 1'b0;
            slot_stop  <= 1'b0;
            win_class  <= WIN_NONE;
            win_lamp   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            credits    <= credit_next;
            slot_start <= 1'b0;
            slot_stop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        slot_start <= 1'b1;
                        win_class  <= WIN_NONE;
                        spin_cnt   <= '0;
                        busy       <= 1'b1;
                        state      <= SPINNING;
                    end
                end
                SPINNING: begin
                    if (stop_rise || spin_cnt == SPIN_LAST) begin
                        slot_stop <= 1'b1;
                        state     <= STOPPING;
                    end else begin
                        spin_cnt <= spin_cnt + SPIN_W'(1);
                    end
                end
                // Digits are captured here so scoring does not depend on the
                // reel block holding them stable through EVAL.
                STOPPING: begin
                    if (reels_done) begin
                        held0 <= reel0;
                        held1 <= reel1;
                        held2 <= reel2;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    win_class <= score;
                    win_lamp  <= (score != WIN_NONE);
                    remaining <= payout;
                    tick_cnt  <= '0;
                    if (payout == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= PAYOUT;
                    end
                end
                PAYOUT: begin
                    if (pay_now) begin
                        tick_cnt  <= '0;
                        remaining <= remaining - PAY_W'(1);
                        if (remaining == PAY_W'(1)) begin
                            win_lamp <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
